i2c_color_reader: RTL and testbench
===================================

# i2c_color_reader

I2C master that reads one burst of five 16-bit colour channels (clear, red, green, blue, infrared) from the external colour sensor. It presents the results to the register bank as parallel channel words, along with busy and NACK indications. The register bank is the consumer of this block's `*_data`, `bsy` and `nack` outputs. One transaction is started per `start` pulse.

## Interface
- `CLK_DIV`, default 125: `clk` cycles per quarter SCL period (tick); must be ≥ 2.
- `SLAVE_ADDR`, default 7'h29: 7-bit I2C address of the sensor.
- `DATA_REG`, default 8'h14: register pointer of the first data byte (clear low byte).
- `REG_WIDTH`, default 16: width of each channel output.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Ports:
  - `clk` in 1: system clock.
  - `rst` in 1: asynchronous active-high reset.
  - `enable` in 1: sensor on (driven from config bit 0); low blocks and aborts transactions.
  - `start` in 1: single-cycle request to run one read burst.
  - `sda_i` in 1: sampled SDA line.
  - `scl_o` out 1: SCL, push-pull; no clock stretching is supported.
  - `sda_oe` out 1: SDA pull-low enable; 1 drives 0, 0 releases the line to 1.
  - `clear_data` out REG_WIDTH: channel result, clear.
  - `red_data` out REG_WIDTH: channel result, red.
  - `green_data` out REG_WIDTH: channel result, green.
  - `blue_data` out REG_WIDTH: channel result, blue.
  - `infrared_data` out REG_WIDTH: channel result, infrared.
  - `data_valid` out 1: one-cycle pulse when all five channels update.
  - `nack` out 1: one-cycle pulse when the slave fails to ACK.
  - `bsy` out 1: high while a transaction is in progress.

## Operation
- Reset values:
  - `scl_o`=1, `sda_oe`=0.
  - All `*_data`=0.
  - `data_valid`=0, `nack`=0, `bsy`=0.
  - FSM in IDLE; tick counter and bit counter cleared.
- A reset asserted mid-transaction takes effect immediately: lines are released with no STOP generated.
- FSM states: IDLE, START, WR_ADDR, WR_ACK, WR_REG, REG_ACK, RSTART, RD_ADDR, RD_ACK, RD_BYTE, M_ACK, STOP.
- IDLE: advances to START when `start` && `enable`. `start` is ignored while `bsy`=1 or `enable`=0; requests are not queued.
- Write phase:
  - START, then WR_ADDR sends {SLAVE_ADDR, 0}, MSB first.
  - WR_ACK samples `sda_i`.
  - WR_REG sends DATA_REG, then REG_ACK samples the ACK.
- Read phase:
  - RSTART issues a repeated start.
  - RD_ADDR sends {SLAVE_ADDR, 1}; RD_ACK samples the ACK.
  - 10 × (RD_BYTE, M_ACK): the master drives ACK (0) after bytes 0–8 and NACK (released) after byte 9, then STOP.
- Byte assembly:
  - Bytes are shifted in MSB first into a 10-byte shadow buffer.
  - Channel k = {byte[2k+1], byte[2k]}: high byte is the second byte on the wire.
  - Channel order k = 0..4 is clear, red, green, blue, infrared.
  - No endianness swap is performed here; the register bank owns it.
- Outputs hold between transactions. The five `*_data` outputs load from the shadow buffer simultaneously, and only on a successful STOP.
- Slave NACK (`sda_i`=1 in WR_ACK, REG_ACK or RD_ACK):
  - `nack` pulses for 1 cycle on the transition into STOP.
  - STOP is issued, then IDLE.
  - `*_data` are unchanged and no `data_valid` pulse is produced.
- `enable` dropping mid-transaction: at the next bit-slot boundary go to STOP, then IDLE. `*_data` are unchanged, with no `data_valid` and no `nack`.

## Timing
- A tick occurs every CLK_DIV `clk` cycles. Each bit slot is 4 ticks (phases 0–3).
- Data bit slot:
  - Phase 0: SCL low, SDA updated at phase start.
  - Phase 1: SCL rises.
  - Phase 2: SCL high, `sda_i` sampled at phase start.
  - Phase 3: SCL falls.
- START / RSTART slot:
  - SDA released with SCL low.
  - SCL rises.
  - SDA pulled low while SCL is high.
  - SCL falls.
- STOP slot:
  - SDA pulled low with SCL low.
  - SCL rises.
  - SDA released while SCL is high.
  - Hold.
- Full successful burst = 120 slots = 480 ticks = 480·CLK_DIV cycles, made up of:
  - START: 1 slot.
  - 27 write/address bits.
  - RSTART: 1 slot.
  - 90 read-phase bits.
  - STOP: 1 slot.
- `bsy` rises the cycle after `start` is accepted. It falls in the cycle the FSM returns to IDLE.
- `data_valid` pulses, and `*_data` update, in that same cycle.
- A new `start` is accepted in the cycle after `bsy` falls.

## Test plan
- Reset, then `start`=1 for 1 cycle with `enable`=1 and CLK_DIV=4. The slave model ACKs and returns bytes 01..0A.
  - `bsy` high for 1920 cycles.
  - `clear_data`=16'h0201, `red_data`=16'h0403, `green_data`=16'h0605, `blue_data`=16'h0807, `infrared_data`=16'h0A09.
  - `data_valid` pulses once.
- Slave NACKs the read address (RD_ACK):
  - `nack` pulses exactly once.
  - A STOP is observed on the bus.
  - `*_data` keep their previous values and `data_valid` stays 0.
- `start` pulses while `bsy`=1, and `start` while `enable`=0:
  - No additional transaction occurs.
  - Bus and outputs match the single-burst case.
- `enable` deasserted during byte 4 of the read:
  - STOP is issued at the next slot boundary and `bsy` falls.
  - No `nack` and no `data_valid`; outputs unchanged.
- `rst` asserted mid-RD_BYTE:
  - Immediately `scl_o`=1, `sda_oe`=0, `bsy`=0 and all `*_data`=0.
  - A subsequent `start` completes a normal burst.
- Protocol monitor on all of the above:
  - SDA never changes while SCL is high, except in START/STOP.
  - Master ACK after bytes 0–8, NACK after byte 9.

Source files
------------

// File: rtl/i2c_color_reader_if.sv
// Bundle of colour-reader signals: control in, I2C pins, channel results out.
// Latency: none (wires only).
// Backpressure: none; results are level-held words plus single-cycle pulses.
// Ports: enable/start/sda_i into the reader; scl_o/sda_oe drive the bus;
// *_data, data_valid, nack, bsy go to the register bank.
interface i2c_color_reader_if #(
  parameter int REG_WIDTH = 16
);
  logic                 enable;
  logic                 start;
  logic                 sda_i;
  logic                 scl_o;
  logic                 sda_oe;
  logic [REG_WIDTH-1:0] clear_data;
  logic [REG_WIDTH-1:0] red_data;
  logic [REG_WIDTH-1:0] green_data;
  logic [REG_WIDTH-1:0] blue_data;
  logic [REG_WIDTH-1:0] infrared_data;
  logic                 data_valid;
  logic                 nack;
  logic                 bsy;

  // Reader side.
  modport master (
    input  enable, start, sda_i,
    output scl_o, sda_oe, clear_data, red_data, green_data, blue_data,
           infrared_data, data_valid, nack, bsy
  );

  // Register bank / bus side.
  modport slave (
    output enable, start, sda_i,
    input  scl_o, sda_oe, clear_data, red_data, green_data, blue_data,
           infrared_data, data_valid, nack, bsy
  );
endinterface

// File: rtl/i2c_color_reader.sv
// I2C master reading five 16-bit colour channels (10 bytes) in one burst.
// Latency: 480 ticks (480*CLK_DIV clk) per successful burst; results land on return to IDLE.
// Backpressure: start ignored while bsy or !enable; requests are not queued.
// Ports: clk, rst (async active-high), bus (master modport): enable, start,
// sda_i in; scl_o, sda_oe, five channel words, data_valid, nack, bsy out.
module i2c_color_reader #(
  parameter int         CLK_DIV    = 125,
  parameter logic [6:0] SLAVE_ADDR = 7'h29,
  parameter logic [7:0] DATA_REG   = 8'h14,
  parameter int         REG_WIDTH  = 16
) (
  input logic                 clk,
  input logic                 rst,
  i2c_color_reader_if.master  bus
);
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] START   = 4'd1;
  localparam logic [3:0] WR_ADDR = 4'd2;
  localparam logic [3:0] WR_ACK  = 4'd3;
  localparam logic [3:0] WR_REG  = 4'd4;
  localparam logic [3:0] REG_ACK = 4'd5;
  localparam logic [3:0] RSTART  = 4'd6;
  localparam logic [3:0] RD_ADDR = 4'd7;
  localparam logic [3:0] RD_ACK  = 4'd8;
  localparam logic [3:0] RD_BYTE = 4'd9;
  localparam logic [3:0] M_ACK   = 4'd10;
  localparam logic [3:0] STOP    = 4'd11;

  logic [3:0]           state;
  logic [DIV_W-1:0]     div_cnt;
  logic [1:0]           phase;
  logic [2:0]           bit_cnt;
  logic [3:0]           byte_cnt;
  logic [7:0]           tx_byte;
  logic                 ack_bad;
  logic                 ok;        // set only when the last master NACK slot completes with enable high
  logic [7:0]           shadow [10];
  logic [REG_WIDTH-1:0] clear_q, red_q, green_q, blue_q, ir_q;
  logic                 data_valid_q, nack_q;
  logic                 tick;
  logic                 scl, sda_oe;

  assign tick = (state != IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      phase        <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      tx_byte      <= '0;
      ack_bad      <= 1'b0;
      ok           <= 1'b0;
      for (int i = 0; i < 10; i++) shadow[i] <= '0;
      clear_q      <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      ir_q         <= '0;
      data_valid_q <= 1'b0;
      nack_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      nack_q       <= 1'b0;
      if (state == IDLE) begin
        div_cnt <= '0;
        phase   <= '0;
        if (bus.start && bus.enable) begin
          state <= START;
          ok    <= 1'b0;
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          phase <= phase + 2'd1;
          // End of phase 1 = start of phase 2: SCL is high, sample the line.
          if (phase == 2'd1) begin
            case (state)
              WR_ACK, REG_ACK, RD_ACK: ack_bad <= bus.sda_i;
              RD_BYTE: shadow[byte_cnt] <= {shadow[byte_cnt][6:0], bus.sda_i};
              default: ;
            endcase
          end
          // End of phase 3 = bit-slot boundary.
          if (phase == 2'd3) begin
            if (!bus.enable && state != STOP) begin
              state <= STOP;
              ok    <= 1'b0;
            end else begin
              case (state)
                START: begin
                  state   <= WR_ADDR;
                  tx_byte <= {SLAVE_ADDR, 1'b0};
                  bit_cnt <= 3'd7;
                end
                WR_ADDR: if (bit_cnt == 3'd0) state <= WR_ACK;  else bit_cnt <= bit_cnt - 3'd1;
                WR_REG:  if (bit_cnt == 3'd0) state <= REG_ACK; else bit_cnt <= bit_cnt - 3'd1;
                RD_ADDR: if (bit_cnt == 3'd0) state <= RD_ACK;  else bit_cnt <= bit_cnt - 3'd1;
                RD_BYTE: if (bit_cnt == 3'd0) state <= M_ACK;   else bit_cnt <= bit_cnt - 3'd1;
                WR_ACK: begin
                  if (ack_bad) begin
                    state  <= STOP;
                    nack_q <= 1'b1;
                  end else begin
                    state   <= WR_REG;
                    tx_byte <= DATA_REG;
                    bit_cnt <= 3'd7;
                  end
                end
                REG_ACK: begin
                  if (ack_bad) begin
                    state  <= STOP;
                    nack_q <= 1'b1;
                  end else begin
                    state <= RSTART;
                  end
                end
                RSTART: begin
                  state   <= RD_ADDR;
                  tx_byte <= {SLAVE_ADDR, 1'b1};
                  bit_cnt <= 3'd7;
                end
                RD_ACK: begin
                  if (ack_bad) begin
                    state  <= STOP;
                    nack_q <= 1'b1;
                  end else begin
                    state    <= RD_BYTE;
                    bit_cnt  <= 3'd7;
                    byte_cnt <= 4'd0;
                  end
                end
                M_ACK: begin
                  if (byte_cnt == 4'd9) begin
                    state <= STOP;
                    ok    <= 1'b1;
                  end else begin
                    byte_cnt <= byte_cnt + 4'd1;
                    state    <= RD_BYTE;
                    bit_cnt  <= 3'd7;
                  end
                end
                STOP: begin
                  state <= IDLE;
                  if (ok) begin
                    // High byte of each channel is the second byte on the wire.
                    clear_q      <= REG_WIDTH'({shadow[1], shadow[0]});
                    red_q        <= REG_WIDTH'({shadow[3], shadow[2]});
                    green_q      <= REG_WIDTH'({shadow[5], shadow[4]});
                    blue_q       <= REG_WIDTH'({shadow[7], shadow[6]});
                    ir_q         <= REG_WIDTH'({shadow[9], shadow[8]});
                    data_valid_q <= 1'b1;
                  end
                end
                default: state <= IDLE;
              endcase
            end
          end
        end
      end
    end
  end

  // Line decode from registered state; IDLE (and reset) releases both lines.
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state)
      START, RSTART: begin
        scl    = (phase == 2'd1) || (phase == 2'd2);
        sda_oe = phase[1];                  // SDA falls while SCL is high
      end
      STOP: begin
        scl    = (phase != 2'd0);
        sda_oe = !phase[1];                 // SDA rises while SCL is high
      end
      WR_ADDR, WR_REG, RD_ADDR: begin
        scl    = (phase == 2'd1) || (phase == 2'd2);
        sda_oe = !tx_byte[bit_cnt];
      end
      WR_ACK, REG_ACK, RD_ACK, RD_BYTE: begin
        scl    = (phase == 2'd1) || (phase == 2'd2);
        sda_oe = 1'b0;
      end
      M_ACK: begin
        scl    = (phase == 2'd1) || (phase == 2'd2);
        sda_oe = (byte_cnt != 4'd9);        // ACK bytes 0-8, NACK the last
      end
      default: ;
    endcase
  end

  assign bus.scl_o         = scl;
  assign bus.sda_oe        = sda_oe;
  assign bus.clear_data    = clear_q;
  assign bus.red_data      = red_q;
  assign bus.green_data    = green_q;
  assign bus.blue_data     = blue_q;
  assign bus.infrared_data = ir_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.nack          = nack_q;
  assign bus.bsy           = (state != IDLE);
endmodule

// File: tb/tb_i2c_color_reader.sv
// Directed bench for i2c_color_reader with a behavioural sensor on the bus.
// Latency: checks taken at fixed cycle offsets after each start pulse.
// Backpressure: none; the sensor model follows SCL edges.
module tb_i2c_color_reader;
  logic clk;
  logic rst;

  i2c_color_reader_if #(.REG_WIDTH(16)) bus ();

  i2c_color_reader #(.CLK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Sensor model configuration (written only by the stimulus block).
  logic       nack_rd;
  logic [7:0] sbase;

  // Monitor state (written only by the monitor block).
  int         bsy_cyc = 0, dv_cnt = 0, nack_cnt = 0, start_cnt = 0, stop_cnt = 0;
  int         st_cnt = 0, nfall = 0;
  logic       p_scl = 1'b1, p_msda = 1'b1, s_drv = 1'b0;
  logic [7:0] cap_wa = '0, cap_reg = '0, cap_ra = '0;
  logic [9:0] mack = '0;

  logic       msda;
  int         fall_f, fall_b, rise_f, rise_b;
  logic       drv_next;
  logic [7:0] byte_v;

  assign msda      = ~bus.sda_oe;
  assign bus.sda_i = msda & ~s_drv;
  assign fall_f    = nfall / 9;
  assign fall_b    = nfall % 9;
  assign rise_f    = (nfall - 1) / 9;
  assign rise_b    = (nfall - 1) % 9;

  // What the sensor drives for the bit that follows an SCL falling edge.
  always_comb begin
    drv_next = 1'b0;
    byte_v   = sbase + 8'(fall_f);
    if (st_cnt == 1) begin
      drv_next = (fall_b == 8) && (fall_f <= 1);
    end else if (st_cnt == 2) begin
      if (fall_f == 0)
        drv_next = (fall_b == 8) && !nack_rd;
      else if (!nack_rd && fall_f <= 10 && fall_b < 8)
        drv_next = !byte_v[7 - fall_b];
    end
  end

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      st_cnt <= 0;
      nfall  <= 0;
      s_drv  <= 1'b0;
      p_scl  <= 1'b1;
      p_msda <= 1'b1;
    end else begin
      p_scl  <= bus.scl_o;
      p_msda <= msda;
      if (bus.bsy)        bsy_cyc  <= bsy_cyc + 1;
      if (bus.data_valid) dv_cnt   <= dv_cnt + 1;
      if (bus.nack)       nack_cnt <= nack_cnt + 1;
      if (p_scl && bus.scl_o && p_msda && !msda) begin
        start_cnt <= start_cnt + 1;
        st_cnt    <= st_cnt + 1;
        nfall     <= 0;
        s_drv     <= 1'b0;
        if (st_cnt == 0) begin
          mack    <= '0;
          cap_wa  <= '0;
          cap_reg <= '0;
          cap_ra  <= '0;
        end
      end else if (p_scl && bus.scl_o && !p_msda && msda) begin
        stop_cnt <= stop_cnt + 1;
        st_cnt   <= 0;
        s_drv    <= 1'b0;
      end else if (p_scl && !bus.scl_o) begin
        nfall <= nfall + 1;
        s_drv <= drv_next;
      end else if (!p_scl && bus.scl_o && nfall > 0) begin
        if (st_cnt == 1 && rise_f == 0 && rise_b < 8) cap_wa  <= {cap_wa[6:0], msda};
        if (st_cnt == 1 && rise_f == 1 && rise_b < 8) cap_reg <= {cap_reg[6:0], msda};
        if (st_cnt == 2 && rise_f == 0 && rise_b < 8) cap_ra  <= {cap_ra[6:0], msda};
        if (st_cnt == 2 && rise_f >= 1 && rise_f <= 10 && rise_b == 8) mack[rise_f-1] <= msda;
      end
    end
  end

  int b0, d0, n0, s0, p0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b0 = bsy_cyc; d0 = dv_cnt; n0 = nack_cnt; s0 = start_cnt; p0 = stop_cnt;
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic chk_data(input string tag, input logic [15:0] c, input logic [15:0] r,
                          input logic [15:0] g, input logic [15:0] bl, input logic [15:0] ir);
    chk({tag, "_clear"}, 32'(bus.clear_data), 32'(c));
    chk({tag, "_red"},   32'(bus.red_data),   32'(r));
    chk({tag, "_green"}, 32'(bus.green_data), 32'(g));
    chk({tag, "_blue"},  32'(bus.blue_data),  32'(bl));
    chk({tag, "_ir"},    32'(bus.infrared_data), 32'(ir));
  endtask

  initial begin
    rst = 1'b1; bus.enable = 1'b0; bus.start = 1'b0; nack_rd = 1'b0; sbase = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_scl", 32'(bus.scl_o), 32'd1);
    chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("rst_bsy", 32'(bus.bsy), 32'd0);
    chk("rst_dv", 32'(bus.data_valid), 32'd0);
    chk("rst_nack", 32'(bus.nack), 32'd0);
    chk_data("rst", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);

    // Full burst, bytes 01..0A.
    bus.enable = 1'b1;
    snap(); pulse_start(); repeat (2000) @(negedge clk);
    chk("b1_bsy_cycles", 32'(bsy_cyc - b0), 32'd1920);
    chk("b1_dv", 32'(dv_cnt - d0), 32'd1);
    chk("b1_nack", 32'(nack_cnt - n0), 32'd0);
    chk("b1_starts", 32'(start_cnt - s0), 32'd2);
    chk("b1_stops", 32'(stop_cnt - p0), 32'd1);
    chk("b1_wr_addr", 32'(cap_wa), 32'h52);
    chk("b1_reg", 32'(cap_reg), 32'h14);
    chk("b1_rd_addr", 32'(cap_ra), 32'h53);
    chk("b1_master_ack", 32'(mack), 32'h200);
    chk("b1_bsy_end", 32'(bus.bsy), 32'd0);
    chk_data("b1", 16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09);

    // Extra start pulses while busy are ignored.
    snap(); pulse_start();
    repeat (300) @(negedge clk); pulse_start();
    repeat (1000) @(negedge clk); pulse_start();
    repeat (700) @(negedge clk);
    chk("busy_bsy_cycles", 32'(bsy_cyc - b0), 32'd1920);
    chk("busy_dv", 32'(dv_cnt - d0), 32'd1);
    chk("busy_starts", 32'(start_cnt - s0), 32'd2);
    chk("busy_stops", 32'(stop_cnt - p0), 32'd1);
    chk("busy_master_ack", 32'(mack), 32'h200);
    chk_data("busy", 16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09);

    // Start with enable low is ignored.
    bus.enable = 1'b0;
    snap(); pulse_start(); repeat (100) @(negedge clk);
    chk("dis_bsy_cycles", 32'(bsy_cyc - b0), 32'd0);
    chk("dis_starts", 32'(start_cnt - s0), 32'd0);

    // Sensor NACKs the read address: STOP after slot 29.
    bus.enable = 1'b1; nack_rd = 1'b1;
    snap(); pulse_start(); repeat (600) @(negedge clk);
    chk("nk_bsy_cycles", 32'(bsy_cyc - b0), 32'd480);
    chk("nk_nack", 32'(nack_cnt - n0), 32'd1);
    chk("nk_dv", 32'(dv_cnt - d0), 32'd0);
    chk("nk_stops", 32'(stop_cnt - p0), 32'd1);
    chk_data("nk", 16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09);
    nack_rd = 1'b0;

    // Enable drops in byte 4 (slot 67); STOP in slot 68, idle after 69 slots.
    sbase = 8'h30;
    snap(); pulse_start(); repeat (1080) @(negedge clk);
    bus.enable = 1'b0;
    repeat (100) @(negedge clk);
    chk("en_bsy_cycles", 32'(bsy_cyc - b0), 32'd1104);
    chk("en_nack", 32'(nack_cnt - n0), 32'd0);
    chk("en_dv", 32'(dv_cnt - d0), 32'd0);
    chk("en_stops", 32'(stop_cnt - p0), 32'd1);
    chk_data("en", 16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09);

    // Second full burst with a different byte pattern.
    bus.enable = 1'b1; sbase = 8'h70;
    snap(); pulse_start(); repeat (2000) @(negedge clk);
    chk("b2_dv", 32'(dv_cnt - d0), 32'd1);
    chk_data("b2", 16'h7271, 16'h7473, 16'h7675, 16'h7877, 16'h7A79);

    // Reset mid RD_BYTE (slot 50, phase 0: SCL low).
    sbase = 8'hC0;
    snap(); pulse_start(); repeat (800) @(negedge clk);
    chk("pre_rst_scl", 32'(bus.scl_o), 32'd0);
    rst = 1'b1;
    #1;
    chk("mr_scl", 32'(bus.scl_o), 32'd1);
    chk("mr_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("mr_bsy", 32'(bus.bsy), 32'd0);
    chk_data("mr", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    snap(); pulse_start(); repeat (2000) @(negedge clk);
    chk("b3_bsy_cycles", 32'(bsy_cyc - b0), 32'd1920);
    chk("b3_dv", 32'(dv_cnt - d0), 32'd1);
    chk("b3_stops", 32'(stop_cnt - p0), 32'd1);
    chk("b3_master_ack", 32'(mack), 32'h200);
    chk_data("b3", 16'hC2C1, 16'hC4C3, 16'hC6C5, 16'hC8C7, 16'hCAC9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
